decoder_scan_ctrl: RTL and testbench

//  Sequencer that drives the select and enable inputs of a downstream 1-of-N decoder.

---
 rtl/decoder_scan_ctrl_pkg.sv | 18 +
 rtl/decoder_scan_ctrl_if.sv | 15 +
 rtl/decoder_scan_ctrl.sv | 105 ++++++++++
 tb/tb_decoder_scan_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_ctrl_pkg.sv
// decoder_scan_ctrl_pkg: shared state encoding and width helpers for the decoder scan sequencer
package decoder_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    function automatic int sel_w(input int n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

    function automatic int cnt_w(input int dwell, input int blank);
        return $clog2((dwell > blank) ? dwell : blank) + 1;
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// decoder_scan_ctrl_if: control inputs and decoder-facing outputs of the scan sequencer
interface decoder_scan_ctrl_if #(
    parameter int SEL_W = 1
);
    logic             start;
    logic             stop;
    logic             continuous;
    logic [SEL_W-1:0] sel;
    logic             enable;
    logic             busy;
    logic             done;

    modport master (output start, stop, continuous, input sel, enable, busy, done);
    modport slave  (input start, stop, continuous, output sel, enable, busy, done);
endinterface

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: steps a 1-of-N decoder select through its channels with dwell and blanking
module decoder_scan_ctrl
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int SEL_W = sel_w(N_CH),
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input logic clk,
    input logic reset_n,
    decoder_scan_ctrl_if.slave bus
);
    localparam int CNT_W = cnt_w(DWELL, BLANK);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    if (N_CH < 2 || DWELL < 1 || BLANK < 0 || SEL_W < sel_w(N_CH)) begin : g_bad_params
        $error("decoder_scan_ctrl: illegal parameters N_CH=%0d DWELL=%0d BLANK=%0d SEL_W=%0d",
               N_CH, DWELL, BLANK, SEL_W);
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [SEL_W-1:0] sel_reg, sel_nx;
    logic             mode, mode_nx;
    logic             done_nx;
    logic             enable_reg, busy_reg, done_reg;

    // next-state logic; stop overrides everything, the last channel of a single-shot scan ends it
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sel_nx   = sel_reg;
        mode_nx  = mode;
        done_nx  = 1'b0;
        if (bus.stop) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            sel_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_nx = ST_ACTIVE;
                        mode_nx  = bus.continuous;
                        cnt_nx   = '0;
                        sel_nx   = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt == DWELL_END) begin
                        cnt_nx = '0;
                        if (sel_reg == LAST_SEL && !mode) begin
                            state_nx = ST_IDLE;
                            sel_nx   = '0;
                            done_nx  = 1'b1;
                        end else begin
                            sel_nx   = (sel_reg == LAST_SEL) ? '0 : sel_reg + SEL_W'(1);
                            state_nx = (BLANK > 0) ? ST_BLANK : ST_ACTIVE;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                ST_BLANK: begin
                    state_nx = (cnt == BLANK_END) ? ST_ACTIVE : ST_BLANK;
                    cnt_nx   = (cnt == BLANK_END) ? '0 : cnt + CNT_W'(1);
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    sel_nx   = '0;
                end
            endcase
        end
    end

    // state and output registers; outputs are decoded from the next state so they come straight off flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sel_reg    <= '0;
            mode       <= 1'b0;
            enable_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sel_reg    <= sel_nx;
            mode       <= mode_nx;
            enable_reg <= (state_nx == ST_ACTIVE);
            busy_reg   <= (state_nx != ST_IDLE);
            done_reg   <= done_nx;
        end
    end

    assign bus.sel    = sel_reg;
    assign bus.enable = enable_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: three parameter sets checked cycle by cycle against a timeline model
module tb_decoder_scan_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic       start_v [3];
    logic       stop_v  [3];
    logic       cont_v  [3];
    logic [1:0] sel_o   [3];
    logic       en_o    [3];
    logic       busy_o  [3];
    logic       done_o  [3];

    decoder_scan_ctrl_if #(.SEL_W(1)) bus0 ();
    decoder_scan_ctrl_if #(.SEL_W(1)) bus1 ();
    decoder_scan_ctrl_if #(.SEL_W(2)) bus2 ();

    decoder_scan_ctrl #(.N_CH(2), .SEL_W(1), .DWELL(4), .BLANK(1)) u0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    decoder_scan_ctrl #(.N_CH(2), .SEL_W(1), .DWELL(4), .BLANK(0)) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    decoder_scan_ctrl #(.N_CH(3), .SEL_W(2), .DWELL(2), .BLANK(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    assign bus0.start = start_v[0];
    assign bus0.stop = stop_v[0];
    assign bus0.continuous = cont_v[0];
    assign bus1.start = start_v[1];
    assign bus1.stop = stop_v[1];
    assign bus1.continuous = cont_v[1];
    assign bus2.start = start_v[2];
    assign bus2.stop = stop_v[2];
    assign bus2.continuous = cont_v[2];
    assign sel_o[0] = {1'b0, bus0.sel};
    assign sel_o[1] = {1'b0, bus1.sel};
    assign sel_o[2] = bus2.sel;
    assign en_o[0] = bus0.enable;
    assign en_o[1] = bus1.enable;
    assign en_o[2] = bus2.enable;
    assign busy_o[0] = bus0.busy;
    assign busy_o[1] = bus1.busy;
    assign busy_o[2] = bus2.busy;
    assign done_o[0] = bus0.done;
    assign done_o[1] = bus1.done;
    assign done_o[2] = bus2.done;

    function automatic int nch(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic int dw(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int bl(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
    endfunction

    // model: a scan is a timeline t = cycles since the first enabled cycle;
    // each channel occupies DWELL enabled cycles followed by BLANK gap cycles
    bit run [3];
    bit cl  [3];
    bit dn  [3];
    int t   [3];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                run[i] <= 1'b0;
                cl[i]  <= 1'b0;
                dn[i]  <= 1'b0;
                t[i]   <= 0;
            end else begin
                dn[i] <= 1'b0;
                if (stop_v[i]) begin
                    run[i] <= 1'b0;
                end else if (!run[i]) begin
                    if (start_v[i]) begin
                        run[i] <= 1'b1;
                        t[i]   <= 0;
                        cl[i]  <= cont_v[i];
                    end
                end else begin
                    t[i] <= t[i] + 1;
                    if (!cl[i] && t[i] + 1 == nch(i) * (dw(i) + bl(i)) - bl(i)) begin
                        run[i] <= 1'b0;
                        dn[i]  <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            int p, c, ph, es, ee, eb, ed;
            p = dw(i) + bl(i);
            c = t[i] / p;
            ph = t[i] % p;
            ee = (run[i] && ph < dw(i)) ? 1 : 0;
            es = !run[i] ? 0 : (ee != 0 ? c % nch(i) : (c + 1) % nch(i));
            eb = run[i] ? 1 : 0;
            ed = dn[i] ? 1 : 0;
            check($sformatf("u%0d.sel", i), int'(sel_o[i]), es);
            check($sformatf("u%0d.enable", i), int'(en_o[i]), ee);
            check($sformatf("u%0d.busy", i), int'(busy_o[i]), eb);
            check($sformatf("u%0d.done", i), int'(done_o[i]), ed);
            check($sformatf("u%0d.busy_and_done", i), int'(busy_o[i] & done_o[i]), 0);
        end
    endtask

    task automatic set_all(input logic s, input logic p, input logic c);
        for (int i = 0; i < 3; i++) begin
            start_v[i] = s;
            stop_v[i]  = p;
            cont_v[i]  = c;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        set_all(1'b0, 1'b0, 1'b0);
        #1 compare_all();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        // single-shot scan
        set_all(1'b1, 1'b0, 1'b0);
        tick();
        set_all(1'b0, 1'b0, 1'b0);
        repeat (16) tick();
        // continuous scan, then stop
        set_all(1'b1, 1'b0, 1'b1);
        tick();
        set_all(1'b0, 1'b0, 1'b0);
        repeat (11) tick();
        set_all(1'b0, 1'b1, 1'b0);
        tick();
        set_all(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        // start and stop together in idle
        set_all(1'b1, 1'b1, 1'b0);
        tick();
        set_all(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        // start re-pulsed during a single-shot scan, with continuous toggling
        set_all(1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 16; k++) begin
            set_all(k % 3 == 0, 1'b0, k % 2 == 0);
            tick();
        end
        set_all(1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        // asynchronous reset in the middle of channel 1 dwell
        set_all(1'b1, 1'b0, 1'b0);
        tick();
        set_all(1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        #2 reset_n = 1'b0;
        #1 compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d.reset_enable", i), int'(en_o[i]), 0);
            check($sformatf("u%0d.reset_busy", i), int'(busy_o[i]), 0);
        end
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 3; i++) begin
                start_v[i] = ($urandom_range(0, 3) == 0);
                stop_v[i]  = ($urandom_range(0, 39) == 0);
                cont_v[i]  = ($urandom_range(0, 1) == 1);
            end
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
